// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD host CMD-line physical stage.
package sd_cmd_pkg;

  localparam int CMD_BITS               = 48;
  localparam int DEFAULT_TURN_CYCLES    = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_TURN,
    ST_WAIT_RESP,
    ST_RECEIVE,
    ST_DONE,
    ST_RELEASE
  } state_e;

endpackage

// File: rtl/sd_cmd_shifter.sv
// 48-bit shift register shared by command transmit and response receive.
// Parallel load has priority over shifting; shifting moves toward the MSB so
// the transmit bit leaves from bit 47 and received bits enter at bit 0.
module sd_cmd_shifter
  import sd_cmd_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [CMD_BITS-1:0] load_data_i,
  input  logic                shift_i,
  input  logic                ser_in_i,
  output logic                ser_out_o,
  output logic [CMD_BITS-1:0] par_o
);

  logic [CMD_BITS-1:0] shreg_q;
  logic [CMD_BITS-1:0] shreg_d;

  // Next register contents: load a command word or shift one bit in.
  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = load_data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[CMD_BITS-2:0], ser_in_i};
    end
  end

  // Register state, cleared on reset so no stale response survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_out_o = shreg_q[CMD_BITS-1];
  assign par_o     = shreg_q;

endmodule

// File: rtl/sd_cmd_phys.sv
// CMD-line physical stage: serializes a command onto the CMD pin, waits for
// the card's start bit, deserializes the response and hands it (or a
// timeout) back to CMD control over a 4-phase strobe/ack handshake.
module sd_cmd_phys
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TURN_CYCLES    = DEFAULT_TURN_CYCLES
) (
  input  logic                iClock_host,
  input  logic                iReset_n,
  input  logic                iStrobe,
  input  logic [CMD_BITS-1:0] iCmd_data,
  input  logic                iAck,
  input  logic                iTimeout_enable,
  input  logic                iCmd_line,
  output logic                oCmd_line,
  output logic                oCmd_oe,
  output logic                oAck,
  output logic                oStrobe,
  output logic [CMD_BITS-1:0] oResponse,
  output logic                oTimeout,
  output logic                oIdle
);

  localparam int CNT_W = $clog2(CMD_BITS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                cmd_line_q, cmd_line_d;
  logic                cmd_oe_q, cmd_oe_d;
  logic                ack_q, ack_d;
  logic                strobe_q, strobe_d;
  logic [CMD_BITS-1:0] response_q, response_d;
  logic                timeout_q, timeout_d;
  logic                idle_q, idle_d;

  logic                sh_load;
  logic                sh_shift;
  logic                sh_in;
  logic                sh_out;
  logic [CMD_BITS-1:0] sh_par;

  sd_cmd_shifter u_shifter (
    .clk         (iClock_host),
    .rst_n       (iReset_n),
    .load_i      (sh_load),
    .load_data_i (iCmd_data),
    .shift_i     (sh_shift),
    .ser_in_i    (sh_in),
    .ser_out_o   (sh_out),
    .par_o       (sh_par)
  );

  // Next-state and next-output logic; the line defaults to released/high.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    cmd_line_d = 1'b1;
    cmd_oe_d   = 1'b0;
    ack_d      = 1'b0;
    strobe_d   = strobe_q;
    response_d = response_q;
    timeout_d  = timeout_q;
    sh_load    = 1'b0;
    sh_shift   = 1'b0;
    sh_in      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (iStrobe) begin
          sh_load    = 1'b1;
          timeout_d  = 1'b0;
          response_d = '0;
          bit_cnt_d  = '0;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bit_cnt_q == CNT_W'(CMD_BITS)) begin
          // Whole word is on the wire: release the pin and tell CMD control.
          ack_d     = 1'b1;
          bit_cnt_d = '0;
          state_d   = ST_TURN;
        end else begin
          cmd_oe_d   = 1'b1;
          cmd_line_d = sh_out;
          sh_shift   = 1'b1;
          bit_cnt_d  = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        // Bus turnaround: the card may glitch the line while it takes over.
        if (bit_cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
          tmo_cnt_d = '0;
          state_d   = ST_WAIT_RESP;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_RESP: begin
        if (!iCmd_line) begin
          // Start bit wins even on the cycle the window would expire.
          sh_shift  = 1'b1;
          sh_in     = 1'b0;
          bit_cnt_d = CNT_W'(1);
          state_d   = ST_RECEIVE;
        end else if (iTimeout_enable) begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
          if (tmo_cnt_q + TMO_W'(1) == TMO_W'(TIMEOUT_CYCLES)) begin
            timeout_d  = 1'b1;
            strobe_d   = 1'b1;
            response_d = '0;
            state_d    = ST_DONE;
          end
        end
      end
      ST_RECEIVE: begin
        if (bit_cnt_q == CNT_W'(CMD_BITS)) begin
          response_d = sh_par;
          strobe_d   = 1'b1;
          state_d    = ST_DONE;
        end else begin
          sh_shift  = 1'b1;
          sh_in     = iCmd_line;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (iAck) begin
          strobe_d = 1'b0;
          state_d  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Both handshake lines must drop so a held strobe cannot retrigger.
        if (!iStrobe && !iAck) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    idle_d = (state_d == ST_IDLE);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge iClock_host or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      cmd_line_q <= 1'b1;
      cmd_oe_q   <= 1'b0;
      ack_q      <= 1'b0;
      strobe_q   <= 1'b0;
      response_q <= '0;
      timeout_q  <= 1'b0;
      idle_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
      cmd_line_q <= cmd_line_d;
      cmd_oe_q   <= cmd_oe_d;
      ack_q      <= ack_d;
      strobe_q   <= strobe_d;
      response_q <= response_d;
      timeout_q  <= timeout_d;
      idle_q     <= idle_d;
    end
  end

  assign oCmd_line = cmd_line_q;
  assign oCmd_oe   = cmd_oe_q;
  assign oAck      = ack_q;
  assign oStrobe   = strobe_q;
  assign oResponse = response_q;
  assign oTimeout  = timeout_q;
  assign oIdle     = idle_q;

endmodule

// File: doc/sd_cmd_phys.md
# sd_cmd_phys

CMD-line physical stage of the SD host, sitting directly between the CMD control block and the SD card CMD pin. It accepts a 48-bit command word from CMD control over a strobe/ack handshake and serializes it MSB-first onto the CMD line. It then releases the line, detects the card's start bit, deserializes the 48-bit response, and returns it to CMD control over a 4-phase strobe/ack handshake. A response timeout is reported when no start bit arrives within the configured window.

## Interface
- TIMEOUT_CYCLES, 64: response-wait window in clocks (Ncr limit); counter width is $clog2(TIMEOUT_CYCLES+1).
- TURN_CYCLES, 2: clocks after the command end bit during which the CMD input is ignored.
- iClock_host  in  1  host clock; all logic on rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iStrobe  in  1  command word valid, from CMD control (its strobe_out).
- iCmd_data  in  48  command word, from CMD control (its cmd_out).
- iAck  in  1  response accepted, from CMD control (its ack_out).
- iTimeout_enable  in  1  1 = enforce TIMEOUT_CYCLES; 0 = wait indefinitely.
- iCmd_line  in  1  CMD pin input.
- oCmd_line  out  1  CMD pin drive value.
- oCmd_oe  out  1  CMD pin output enable.
- oAck  out  1  one-cycle pulse: command fully shifted out.
- oStrobe  out  1  response (or timeout) valid, to CMD control (its strobe_in).
- oResponse  out  48  received response, to CMD control (its cmd_in).
- oTimeout  out  1  response timeout, to CMD control (its timeout).
- oIdle  out  1  block in IDLE.

## Operation
- Reset values: oCmd_line=1, oCmd_oe=0, oAck=0, oStrobe=0, oResponse=0, oTimeout=0, oIdle=1; state IDLE; all counters 0.
- States: IDLE, SEND, TURN, WAIT_RESP, RECEIVE, DONE, RELEASE.
- IDLE: when iStrobe=1, latch iCmd_data into the shift register, clear oTimeout and oResponse, and go to SEND.
- SEND: 48 cycles. Drive oCmd_oe=1 and oCmd_line=bit[47-n] in cycle n. Data is sent as-is; CRC and end bit are CMD control's responsibility. Then go to TURN, set oCmd_oe=0 and oCmd_line=1, and pulse oAck.
- TURN: TURN_CYCLES cycles. Ignore iCmd_line. Then go to WAIT_RESP with the timeout counter at 0.
- WAIT_RESP: sample iCmd_line every cycle.
  - Sampled 0 = start bit: shift it in as response bit 47 and go to RECEIVE.
  - Otherwise increment the counter. If iTimeout_enable=1 and the counter reaches TIMEOUT_CYCLES, set oTimeout=1 and go to DONE with oResponse=0.
- RECEIVE: shift in 47 more bits MSB-first. After the last bit, load oResponse and go to DONE.
- DONE: hold oStrobe=1 with oResponse/oTimeout stable. When iAck=1, drop oStrobe and go to RELEASE.
- RELEASE: wait until iStrobe=0 and iAck=0, then go to IDLE. This prevents a held iStrobe from retriggering a command.
- iStrobe outside IDLE is ignored; iCmd_data is not re-sampled.
- iAck outside DONE is ignored.
- oTimeout stays set until the next command is accepted in IDLE.

## Timing
- iStrobe sampled high at edge k: oCmd_oe=1 with bit 47 on the line after edge k+1; bit 0 after edge k+48.
- oCmd_oe=0 and oAck=1 after edge k+49; oAck lasts exactly one cycle.
- With TURN_CYCLES=2, WAIT_RESP begins after edge k+51.
- Start bit sampled at edge s: last bit sampled at edge s+47; oStrobe=1 and oResponse valid after edge s+48.
- Timeout: oTimeout=1 and oStrobe=1 after the edge where WAIT_RESP has sampled TIMEOUT_CYCLES consecutive 1s.
- If the start bit is sampled on the same edge the counter would reach the limit, the start bit wins and no timeout is raised.
- iAck sampled high at edge a: oStrobe=0 after edge a.
- If iTimeout_enable falls during WAIT_RESP, the counter freezes at its current value and no timeout fires.
- Asynchronous reset at any point, including mid-SEND: oCmd_oe drops immediately and no partial response is ever strobed.

## Structure
- Package sd_cmd_pkg holds:
  - the state encoding;
  - CMD_BITS=48;
  - default TURN_CYCLES and TIMEOUT_CYCLES.
- Sub-module sd_cmd_shifter: 48-bit register with parallel load, serial MSB-out, serial MSB-in, parallel out, and shift-enable. The same register serves both TX and RX.
- The FSM, bit counter and timeout counter stay in sd_cmd_phys.

## Test plan
- Send: iCmd_data=48'h40_0000_0000_95 with iStrobe held high → oCmd_line carries exactly those 48 bits MSB-first with oCmd_oe=1 for 48 cycles; oAck pulses once; no retrigger until iStrobe goes low.
- Response: card drives 2 idle 1s, then 48'h3F_1234_5678_01 MSB-first → oResponse=48'h3F12345678_01, oStrobe=1 until iAck; oTimeout=0.
- Timeout: line held at 1 with iTimeout_enable=1 → oTimeout=1 and oStrobe=1 exactly 64 cycles into WAIT_RESP, with oResponse=0. Repeat with iTimeout_enable=0: no strobe after 200 cycles.
- Boundary: start bit arrives on the 64th WAIT_RESP sample → normal response, no timeout.
- Reset mid-operation: iReset_n low during SEND bit 20 → all outputs return to reset values immediately; the next command runs cleanly.
- Handshake robustness: iAck pulsed during SEND and during RECEIVE → ignored; response is still delivered and requires a fresh iAck.
